// File: rtl/seed_a_sched_pkg.sv
// Shared definitions for the seedA storage scheduler: storage command
// encoding, seed geometry and scheduler FSM states.
package seed_a_sched_pkg;

    localparam int   SeedAStorageCMD_SIZE = 1;
    localparam logic CMD_IN               = 1'b1;
    localparam logic CMD_OUT              = 1'b0;
    localparam int   SEED_WORDS           = 2;
    localparam int   WORD_W               = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER_IN,
        XFER_OUT
    } schedState;

    // Index width that stays legal for a single-entry range
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seed_a_sched_if.sv
// Handshake bundle between the scheduler, its writer, its readers and the
// seedA storage block. slave = scheduler side, master = environment side.
interface seed_a_sched_if
    import seed_a_sched_pkg::*;
#(
    parameter int NR = 2
);
    logic              wr_cmd_isReady;
    logic              wr_cmd_canReceive;
    logic [WORD_W-1:0] wr_in;
    logic              wr_in_isReady;
    logic              wr_in_canReceive;
    logic              wr_in_isLast;

    logic [NR-1:0]     rd_cmd_isReady;
    logic [NR-1:0]     rd_cmd_canReceive;
    logic [WORD_W-1:0] rd_out;
    logic [NR-1:0]     rd_out_isReady;
    logic [NR-1:0]     rd_out_canReceive;
    logic              rd_out_isLast;

    logic              invalidate;
    logic              seed_valid;
    logic              busy;
    logic              proto_err;

    logic              st_cmd;
    logic              st_cmd_isReady;
    logic              st_cmd_canReceive;
    logic [WORD_W-1:0] st_in;
    logic              st_in_isReady;
    logic              st_in_canReceive;
    logic              st_in_isLast;
    logic [WORD_W-1:0] st_out;
    logic              st_out_isReady;
    logic              st_out_canReceive;
    logic              st_out_isLast;

    modport slave (
        input  wr_cmd_isReady, wr_in, wr_in_isReady,
        output wr_cmd_canReceive, wr_in_canReceive, wr_in_isLast,
        input  rd_cmd_isReady, rd_out_canReceive,
        output rd_cmd_canReceive, rd_out, rd_out_isReady, rd_out_isLast,
        input  invalidate,
        output seed_valid, busy, proto_err,
        output st_cmd, st_cmd_isReady, st_in, st_in_isReady, st_out_canReceive,
        input  st_cmd_canReceive, st_in_canReceive, st_in_isLast,
        input  st_out, st_out_isReady, st_out_isLast
    );

    modport master (
        output wr_cmd_isReady, wr_in, wr_in_isReady,
        input  wr_cmd_canReceive, wr_in_canReceive, wr_in_isLast,
        output rd_cmd_isReady, rd_out_canReceive,
        input  rd_cmd_canReceive, rd_out, rd_out_isReady, rd_out_isLast,
        output invalidate,
        input  seed_valid, busy, proto_err,
        input  st_cmd, st_cmd_isReady, st_in, st_in_isReady, st_out_canReceive,
        output st_cmd_canReceive, st_in_canReceive, st_in_isLast,
        output st_out, st_out_isReady, st_out_isLast
    );

endinterface

// File: rtl/seed_a_sched_rr_arbiter_onehot.sv
// Round-robin arbiter: grants the first active request at or after ptr,
// wrapping around. Purely combinational, one-hot (or zero) grant.
module rr_arbiter_onehot
    import seed_a_sched_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idxWidth(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan requests starting at ptr, first hit wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % 32'(N));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seed_a_sched.sv
// Arbitrates one seed writer and NR readers onto the single seedA storage
// port, tracks seed validity and checks storage isLast against word count.
module seed_a_sched
    import seed_a_sched_pkg::*;
#(
    parameter int NR    = 2,
    parameter int WORDS = SEED_WORDS
) (
    input logic          clk,
    input logic          rst,
    seed_a_sched_if.slave bus
);

    localparam int            PW         = idxWidth(NR);
    localparam int            WW         = idxWidth(WORDS);
    localparam logic [PW-1:0] LAST_OWNER = PW'(NR - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS - 1);

    schedState     state, stateNext;
    logic          opReg;
    logic [PW-1:0] owner, rrPtr, arbIdx;
    logic [WW-1:0] wcnt;
    logic          seedValidReg, busyReg, protoErrReg;
    logic          wrGrantPulse;
    logic [NR-1:0] rdGrantPulse, arbGrant;
    logic          grantWr, grantRd;
    logic          inHs, outHs, wordLast, stLast;

    rr_arbiter_onehot #(.N(NR), .PW(PW)) uArb (
        .req   (bus.rd_cmd_isReady),
        .ptr   (rrPtr),
        .grant (arbGrant)
    );

    assign inHs     = (state == XFER_IN) && bus.wr_in_isReady && bus.st_in_canReceive;
    assign outHs    = (state == XFER_OUT) && bus.st_out_isReady && bus.rd_out_canReceive[owner];
    assign wordLast = (wcnt == LAST_WORD);
    assign stLast   = (state == XFER_IN) ? bus.st_in_isLast : bus.st_out_isLast;

    assign bus.wr_cmd_canReceive = wrGrantPulse;
    assign bus.rd_cmd_canReceive = rdGrantPulse;
    assign bus.st_cmd_isReady    = (state == ISSUE);
    assign bus.st_cmd            = opReg;
    assign bus.seed_valid        = seedValidReg;
    assign bus.busy              = busyReg;
    assign bus.proto_err         = protoErrReg;

    // Convert the one-hot reader grant to an owner index
    always_comb begin
        arbIdx = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (arbGrant[i]) arbIdx = PW'(i);
        end
    end

    // Next state and IDLE arbitration: writer first, readers only with a valid seed
    always_comb begin
        stateNext = state;
        grantWr   = 1'b0;
        grantRd   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_cmd_isReady) begin
                    grantWr   = 1'b1;
                    stateNext = ISSUE;
                end else if (seedValidReg && (|arbGrant)) begin
                    grantRd   = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE:    if (bus.st_cmd_canReceive) stateNext = (opReg == CMD_IN) ? XFER_IN : XFER_OUT;
            XFER_IN:  if (inHs && wordLast) stateNext = IDLE;
            XFER_OUT: if (outHs && wordLast) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Data pass-through, steered only while the matching transfer is active
    always_comb begin
        bus.st_in             = '0;
        bus.st_in_isReady     = 1'b0;
        bus.wr_in_canReceive  = 1'b0;
        bus.wr_in_isLast      = 1'b0;
        bus.rd_out            = '0;
        bus.rd_out_isReady    = '0;
        bus.rd_out_isLast     = 1'b0;
        bus.st_out_canReceive = 1'b0;
        if (state == XFER_IN) begin
            bus.st_in            = bus.wr_in;
            bus.st_in_isReady    = bus.wr_in_isReady;
            bus.wr_in_canReceive = bus.st_in_canReceive;
            bus.wr_in_isLast     = bus.st_in_isLast;
        end
        if (state == XFER_OUT) begin
            bus.rd_out                = bus.st_out;
            bus.rd_out_isReady[owner] = bus.st_out_isReady;
            bus.rd_out_isLast         = bus.st_out_isLast;
            bus.st_out_canReceive     = bus.rd_out_canReceive[owner];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Grant pulses, transfer bookkeeping and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg        <= CMD_OUT;
            owner        <= '0;
            rrPtr        <= '0;
            wcnt         <= '0;
            seedValidReg <= 1'b0;
            busyReg      <= 1'b0;
            protoErrReg  <= 1'b0;
            wrGrantPulse <= 1'b0;
            rdGrantPulse <= '0;
        end else begin
            wrGrantPulse <= grantWr;
            rdGrantPulse <= grantRd ? arbGrant : '0;
            if (grantWr) opReg <= CMD_IN;
            if (grantRd) begin
                opReg <= CMD_OUT;
                owner <= arbIdx;
            end
            if (grantWr || grantRd) busyReg <= 1'b1;
            if ((state == ISSUE) && bus.st_cmd_canReceive) wcnt <= '0;
            if (inHs || outHs) begin
                wcnt <= wcnt + 1'b1;
                if (stLast != wordLast) protoErrReg <= 1'b1;
                if (wordLast) busyReg <= 1'b0;
            end
            if (outHs && wordLast) rrPtr <= (owner == LAST_OWNER) ? '0 : owner + 1'b1;
            // A completing write overrides a same-cycle invalidate
            if (inHs && wordLast)    seedValidReg <= 1'b1;
            else if (bus.invalidate) seedValidReg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seed_a_sched.sv
// Scoreboard bench for seed_a_sched with a behavioural two-word storage model.
module tb_seed_a_sched;
    import seed_a_sched_pkg::*;

    localparam int NR = 2;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } wordExp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seed_a_sched_if #(.NR(NR)) bus();

    seed_a_sched #(.NR(NR), .WORDS(SEED_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus-owned drivers
    logic          wrReq   = 1'b0;
    logic [63:0]   wrData  = '0;
    logic          wrInV   = 1'b0;
    logic [NR-1:0] rdWant  = '0;
    logic [NR-1:0] rdAcc   = '1;
    logic          inval   = 1'b0;
    logic          badLast = 1'b0;

    assign bus.wr_cmd_isReady    = wrReq;
    assign bus.wr_in             = wrData;
    assign bus.wr_in_isReady     = wrInV;
    assign bus.rd_cmd_isReady    = rdWant;
    assign bus.rd_out_canReceive = rdAcc;
    assign bus.invalidate        = inval;

    // Storage model: accepts every cmd at once, isLast flags the second word
    logic [63:0] mem [2];
    int          stMode = 0;
    int          stIdx  = 0;
    always @(posedge clk) begin
        if (bus.st_cmd_isReady && bus.st_cmd_canReceive) begin
            stMode <= bus.st_cmd ? 1 : 2;
            stIdx  <= 0;
        end else if (bus.st_in_isReady && bus.st_in_canReceive) begin
            mem[stIdx[0]] <= bus.st_in;
            stIdx <= stIdx + 1;
            if (stIdx == 1) stMode <= 0;
        end else if (bus.st_out_isReady && bus.st_out_canReceive) begin
            stIdx <= stIdx + 1;
            if (stIdx == 1) stMode <= 0;
        end
    end
    assign bus.st_cmd_canReceive = 1'b1;
    assign bus.st_in_canReceive  = (stMode == 1);
    assign bus.st_in_isLast      = (stIdx == 1) ^ badLast;
    assign bus.st_out_isReady    = (stMode == 2);
    assign bus.st_out            = mem[stIdx[0]];
    assign bus.st_out_isLast     = (stIdx == 1);

    // Scoreboard
    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  grantQ [$];
    logic        cmdQ [$];
    wordExp      wordQ [$];
    int          curOwner = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        nChecks++;
        nFails++;
        $display("FAIL %s: unexpected event %h, expected nothing (t=%0t)", name, act, $time);
    endtask

    logic [7:0] actGrant, expGrant;
    logic       expCmd;
    wordExp     expWord;

    // Monitor: pop and compare whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_cmd_canReceive || (bus.rd_cmd_canReceive != '0)) begin
                if (bus.wr_cmd_canReceive && (bus.rd_cmd_canReceive == '0))
                    actGrant = 8'hFF;
                else if (!bus.wr_cmd_canReceive && $onehot(bus.rd_cmd_canReceive))
                    actGrant = {7'd0, bus.rd_cmd_canReceive[1]};
                else
                    actGrant = 8'hEE;
                if (grantQ.size() == 0) unexpected("grant", 64'(actGrant));
                else begin
                    expGrant = grantQ.pop_front();
                    check("grant order", 64'(actGrant), 64'(expGrant));
                    if (expGrant != 8'hFF) curOwner = int'(expGrant);
                end
            end
            if (bus.st_cmd_isReady && bus.st_cmd_canReceive) begin
                if (cmdQ.size() == 0) unexpected("storage cmd", 64'(bus.st_cmd));
                else begin
                    expCmd = cmdQ.pop_front();
                    check("storage cmd", 64'(bus.st_cmd), 64'(expCmd));
                end
            end
            if (bus.wr_in_isReady && bus.wr_in_canReceive) begin
                if (wordQ.size() == 0) unexpected("write word", bus.st_in);
                else begin
                    expWord = wordQ.pop_front();
                    check("write word data", bus.st_in, expWord.data);
                    check("write word isLast", 64'(bus.wr_in_isLast), 64'(expWord.last));
                end
            end
            if ((bus.rd_out_isReady & bus.rd_out_canReceive) != '0) begin
                if (wordQ.size() == 0) unexpected("read word", bus.rd_out);
                else begin
                    expWord = wordQ.pop_front();
                    check("read word data", bus.rd_out, expWord.data);
                    check("read word isLast", 64'(bus.rd_out_isLast), 64'(expWord.last));
                end
            end
            if (bus.rd_out_isReady != '0)
                check("reader isReady owner", 64'(bus.rd_out_isReady), 64'(2'b01 << curOwner));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWrite(input logic [63:0] w0, input logic [63:0] w1,
                             input logic l0, input logic l1);
        grantQ.push_back(8'hFF);
        cmdQ.push_back(CMD_IN);
        wordQ.push_back('{data: w0, last: l0});
        wordQ.push_back('{data: w1, last: l1});
    endtask

    task automatic pushRead(input int i, input logic [63:0] w0, input logic [63:0] w1);
        grantQ.push_back(8'(i));
        cmdQ.push_back(CMD_OUT);
        wordQ.push_back('{data: w0, last: 1'b0});
        wordQ.push_back('{data: w1, last: 1'b1});
    endtask

    task automatic sendWord(input logic [63:0] w);
        int t = 0;
        wrData = w;
        wrInV  = 1'b1;
        while (!bus.wr_in_canReceive && t < 100) begin tick(); t++; end
        check("writer word accept wait", 64'(t < 100), 64'd1);
        tick();
    endtask

    task automatic waitWrGrant();
        int t = 0;
        wrReq = 1'b1;
        while (!bus.wr_cmd_canReceive && t < 100) begin tick(); t++; end
        check("writer grant wait", 64'(t < 100), 64'd1);
        wrReq = 1'b0;
    endtask

    task automatic doWrite(input logic [63:0] w0, input logic [63:0] w1);
        waitWrGrant();
        sendWord(w0);
        sendWord(w1);
        wrInV = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        do begin tick(); t++; end while (bus.busy && t < 100);
        check("transfer end wait", 64'(t < 100), 64'd1);
    endtask

    task automatic waitRdGrant(input int i);
        int t = 0;
        while (bus.rd_cmd_canReceive[i] !== 1'b1 && t < 100) begin tick(); t++; end
        check("read grant wait", 64'(t < 100), 64'd1);
        rdWant[i] = 1'b0;
        check("busy in ISSUE", 64'(bus.busy), 64'd1);
    endtask

    function automatic logic [63:0] quietOutputs();
        return 64'({bus.wr_cmd_canReceive, bus.wr_in_canReceive, bus.wr_in_isLast,
                    bus.rd_cmd_canReceive, bus.rd_out_isReady, bus.rd_out_isLast,
                    bus.seed_valid, bus.busy, bus.proto_err, bus.st_cmd_isReady,
                    bus.st_in_isReady, bus.st_out_canReceive});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset outputs", quietOutputs(), 64'd0);
        rst = 1'b0;
        tick();

        // 1: read blocked until a seed is loaded, then served in order
        rdWant[0] = 1'b1;
        repeat (5) tick();
        check("read blocked without seed", 64'(bus.rd_cmd_canReceive), 64'd0);
        check("seed_valid before load", 64'(bus.seed_valid), 64'd0);
        pushWrite(64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA2, 1'b0, 1'b1);
        pushRead(0, 64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA2);
        doWrite(64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA2);
        check("seed_valid after load", 64'(bus.seed_valid), 64'd1);
        waitRdGrant(0);
        waitIdle();

        // 3: writer and reader 1 together; writer first, reader with no bubble
        pushWrite(64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002, 1'b0, 1'b1);
        pushRead(1, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002);
        rdWant[1] = 1'b1;
        doWrite(64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002);
        tick();
        check("zero-bubble reader grant", 64'(bus.rd_cmd_canReceive), 64'(2'b10));
        waitRdGrant(1);
        waitIdle();

        // 2: two continuous readers alternate
        for (int n = 0; n < 4; n++)
            pushRead(n % 2, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002);
        rdWant = 2'b11;
        for (int n = 0; n < 4; n++) begin
            int t = 0;
            while (bus.rd_cmd_canReceive == '0 && t < 100) begin tick(); t++; end
            check("alternating grant wait", 64'(t < 100), 64'd1);
            if (n == 3) rdWant = '0;
            tick();
        end
        waitIdle();

        // 4: reader backpressure holds the second word
        pushRead(0, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002);
        rdWant[0] = 1'b1;
        waitRdGrant(0);
        begin
            int t = 0;
            while (!(bus.rd_out_isReady[0] && bus.rd_out_canReceive[0]) && t < 100) begin tick(); t++; end
            check("first read word wait", 64'(t < 100), 64'd1);
        end
        tick();
        rdAcc[0] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("stalled word stable", bus.rd_out, 64'h3333_0000_0000_0002);
            check("busy while stalled", 64'(bus.busy), 64'd1);
            tick();
        end
        rdAcc[0] = 1'b1;
        waitIdle();

        // 5: invalidate mid-read; read completes, later reads wait for a new seed
        pushRead(0, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002);
        rdWant[0] = 1'b1;
        waitRdGrant(0);
        tick();
        inval = 1'b1;
        tick();
        inval = 1'b0;
        waitIdle();
        check("seed_valid after invalidate", 64'(bus.seed_valid), 64'd0);
        rdWant[1] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("read blocked after invalidate", 64'(bus.rd_cmd_canReceive), 64'd0);
        end
        pushWrite(64'hB000_0000_0000_00B1, 64'hB000_0000_0000_00B2, 1'b0, 1'b1);
        pushRead(1, 64'hB000_0000_0000_00B1, 64'hB000_0000_0000_00B2);
        doWrite(64'hB000_0000_0000_00B1, 64'hB000_0000_0000_00B2);
        waitRdGrant(1);
        waitIdle();

        // 6: reset after the first write word, then an isLast disagreement
        grantQ.push_back(8'hFF);
        cmdQ.push_back(CMD_IN);
        wordQ.push_back('{data: 64'hC000_0000_0000_00C1, last: 1'b0});
        waitWrGrant();
        sendWord(64'hC000_0000_0000_00C1);
        #2 rst = 1'b1;
        #1 check("outputs in mid-transfer reset", quietOutputs(), 64'd0);
        wrInV = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        badLast = 1'b1;
        pushWrite(64'hD000_0000_0000_00D1, 64'hD000_0000_0000_00D2, 1'b1, 1'b0);
        doWrite(64'hD000_0000_0000_00D1, 64'hD000_0000_0000_00D2);
        badLast = 1'b0;
        check("proto_err on early isLast", 64'(bus.proto_err), 64'd1);
        check("seed_valid ends on count", 64'(bus.seed_valid), 64'd1);
        pushRead(0, 64'hD000_0000_0000_00D1, 64'hD000_0000_0000_00D2);
        rdWant[0] = 1'b1;
        waitRdGrant(0);
        waitIdle();
        check("proto_err sticky", 64'(bus.proto_err), 64'd1);
        rst = 1'b1;
        tick();
        check("proto_err cleared by reset", 64'(bus.proto_err), 64'd0);
        rst = 1'b0;
        tick();

        check("scoreboard drained", 64'(grantQ.size() + cmdQ.size() + wordQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/seed_a_sched.md
Name: seed_a_sched

Overview:
Controller and arbiter in front of the 128-bit seedA storage block (2 x 64-bit words, 1-bit cmd: 1 = load/in, 0 = read/out). It serialises one writer (the seedA generator) and NR readers (matrix-A expanders) onto the storage's single cmd/in/out streams. It tracks whether a valid seed is held, and blocks reads until one is. It sits between the keygen/encaps sequencer and the storage, and owns all storage cmd traffic.

Parameters:
NR, 2, number of reader requesters (1..8)
WORDS, 2, 64-bit words per seed transfer (must match storage capacity)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous active-high
wr_cmd_isReady  in  1  writer requests a seed load
wr_cmd_canReceive  out  1  load request accepted (1-cycle pulse on grant)
wr_in  in  64  seed word from writer
wr_in_isReady  in  1  writer word valid
wr_in_canReceive  out  1  writer word accepted
wr_in_isLast  out  1  current writer word is the last
rd_cmd_isReady  in  NR  per-reader read request
rd_cmd_canReceive  out  NR  per-reader grant pulse (one-hot)
rd_out  out  64  seed word, shared by all readers
rd_out_isReady  out  NR  word valid, set only for the granted reader
rd_out_canReceive  in  NR  per-reader ready
rd_out_isLast  out  1  current read word is the last
invalidate  in  1  clear seed_valid (new session)
seed_valid  out  1  storage holds a complete seed
busy  out  1  transfer in progress
proto_err  out  1  sticky: storage isLast disagrees with word count
st_cmd  out  1  to storage cmd (1 = in, 0 = out)
st_cmd_isReady  out  1  storage cmd valid
st_cmd_canReceive  in  1  storage cmd accepted
st_in  out  64  to storage in
st_in_isReady  out  1
st_in_canReceive  in  1
st_in_isLast  in  1
st_out  in  64  from storage out
st_out_isReady  in  1
st_out_canReceive  out  1
st_out_isLast  in  1

Behaviour:
- Reset (async): state=IDLE, seed_valid=0, busy=0, proto_err=0, rr_ptr=0, wcnt=0. All isReady/canReceive outputs are 0. Storage data is not cleared; the seed must be reloaded because seed_valid=0.
- States: IDLE, ISSUE, XFER_IN, XFER_OUT.
- IDLE arbitration, one decision per cycle:
  - A writer request has priority over all reads.
  - Otherwise, if seed_valid=1, pick the first requesting reader at or after rr_ptr (round-robin).
  - Reads are never granted while seed_valid=0. Requests stay pending and are not dropped.
  - On a grant: pulse the matching cmd_canReceive for 1 cycle, latch op and owner index, go to ISSUE.
- ISSUE: drive st_cmd_isReady=1 with st_cmd = op, held until st_cmd_canReceive. Then go to XFER_IN or XFER_OUT, wcnt=0. busy=1 from ISSUE through the end of the transfer.
- XFER_IN: combinational pass-through.
  - st_in=wr_in, st_in_isReady=wr_in_isReady, wr_in_canReceive=st_in_canReceive, wr_in_isLast=st_in_isLast.
  - Each handshake increments wcnt.
  - The handshake with wcnt==WORDS-1 ends the transfer: seed_valid<=1, state<=IDLE.
- XFER_OUT: pass-through to the owner only.
  - rd_out=st_out, rd_out_isReady[owner]=st_out_isReady, st_out_canReceive=rd_out_canReceive[owner].
  - Each handshake increments wcnt. The last handshake returns to IDLE and sets rr_ptr<=owner+1 (mod NR).
- proto_err is set if, on any handshake, st_*_isLast != (wcnt==WORDS-1). The transfer still ends on the count.
- Zero bubble: IDLE can grant in the cycle after a transfer's last handshake.
- Simultaneous events:
  - invalidate clears seed_valid in IDLE or XFER_OUT; an in-flight read completes.
  - invalidate in the same cycle as a write completion: the write wins, seed_valid=1.
  - invalidate during XFER_IN clears seed_valid, but the completion then sets it.
- A writer request arriving during a read waits; it is granted at the next IDLE ahead of readers.
- Outputs other than pass-through signals are registered; pass-through paths are combinational (0-cycle latency).

Decomposition:
- Shared package (lib.v defines): SeedAStorageCMD_SIZE, CMD_IN=1'b1, CMD_OUT=1'b0, state encodings, SEED_WORDS=2.
- One natural sub-module: rr_arbiter_onehot (NR requests, pointer in -> one-hot grant). Reusable for other shared resources.

Test Plan:
1. Reset, then reader 0 requests -> no grant while seed_valid=0; writer loads 0xA..A1, 0xA..A2 -> st_cmd=1 accepted, wr_in_isLast on word 2, seed_valid=1, then reader 0 granted and receives both words in order.
2. Readers 0 and 1 request continuously with seed valid -> grants alternate 0,1,0,1. rd_out_isReady is never asserted for the non-owner.
3. Writer and reader 1 request in the same IDLE cycle -> writer granted first, reader 1 granted the cycle after the write's last handshake.
4. Backpressure: hold rd_out_canReceive[0]=0 for 5 cycles mid-read -> word 2 held stable, no loss, busy=1 throughout.
5. invalidate during XFER_OUT -> read completes, seed_valid=0 afterward; a new read request blocks until the next write.
6. Assert rst mid-XFER_IN after word 1 -> all outputs 0 immediately, seed_valid=0. Storage asserting isLast on word 1 in a later transfer -> proto_err=1, sticky until rst.
